dl_port_responder: RTL and testbench

Responder end of the toggle-handshake memory port driven by the ROM download controller (`portN_req`/`portN_ack`/`portN_a`/`portN_ds`/`portN_we`/`portN_d`/`portN_q`). Detects each request toggle and posts writes into a small FIFO. Drains the FIFO, and serves reads in order, through a single-outstanding valid/ready memory command interface. Returns a matching `port_ack` toggle per request. Sits between the download logic and a memory controller or BRAM in the `clk_sys` domain.

---
 rtl/dl_port_responder.sv | 203 ++++++++++++++++++++
 tb/tb_dl_port_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_port_responder.sv
// dl_port_responder
// Responder end of the toggle-handshake download port. Writes are posted into
// a small FIFO and acked at once. Reads wait until the FIFO has drained and
// are acked when the memory returns data. All memory traffic goes through a
// single-outstanding valid/ready command interface.
// Optional feature macro: DL_BYTE_MERGE_EN. When defined, a write to the same
// address as the FIFO tail entry with disjoint byte strobes is folded into
// that entry instead of taking a new one.
module dl_port_responder #(
    parameter int AW    = 23,
    parameter int DEPTH = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          port_req,
    output logic          port_ack,
    input  logic [AW-1:0] port_a,
    input  logic [1:0]    port_ds,
    input  logic          port_we,
    input  logic [15:0]   port_d,
    output logic [15:0]   port_q,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [1:0]    mem_ds,
    output logic [15:0]   mem_wdata,
    input  logic          mem_rvalid,
    input  logic [15:0]   mem_rdata,
    output logic          busy
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] CNT_ONE = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RWAIT
    } state_t;

    state_t state;

    // Posted-write storage
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [1:0]    fifo_ds   [DEPTH];
    logic [15:0]   fifo_data [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] rd_nxt_idx;
    logic [PW-1:0] count;
    logic [PW-1:0] count_nxt;
    logic          fifo_empty;
    logic          fifo_full;

    logic pending;
    logic pop;
    logic push;
    logic merge_ok;
    logic wr_accept;
    logic rd_issue;
    logic rd_done;
    logic rd_inflight_nxt;

    assign wr_idx     = wr_ptr[IW-1:0];
    assign rd_idx     = rd_ptr[IW-1:0];
    assign rd_nxt_idx = rd_idx + IW'(1);
    assign count      = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

    // A request is outstanding whenever the two toggles disagree
    assign pending = port_req ^ port_ack;

    // The head entry leaves the FIFO when its command is accepted
    assign pop = (state == S_WR) && mem_ready;

`ifdef DL_BYTE_MERGE_EN
    localparam logic [PW-1:0] CNT_TWO = PW'(2);
    logic [IW-1:0] tail_idx;
    logic          tail_free;

    assign tail_idx = wr_idx - IW'(1);
    // The tail may be modified only while it is neither the head being
    // issued nor the entry about to be loaded behind the head
    assign tail_free = (count >= CNT_TWO) && !(pop && (count == CNT_TWO));
    assign merge_ok  = pending && port_we && tail_free &&
                       (fifo_addr[tail_idx] == port_a) &&
                       ((fifo_ds[tail_idx] & port_ds) == 2'b00);
`else
    assign merge_ok = 1'b0;
`endif

    // A pop in the same cycle frees a slot even when the FIFO is full
    assign push      = pending && port_we && !merge_ok && (!fifo_full || pop);
    assign wr_accept = push || merge_ok;
    // Reads go out only once every earlier write has left the FIFO
    assign rd_issue  = (state == S_IDLE) && fifo_empty && pending && !port_we;
    assign rd_done   = (state == S_RWAIT) && mem_rvalid;

    assign count_nxt       = count + PW'(push) - PW'(pop);
    assign rd_inflight_nxt = rd_issue || (state == S_RD) || ((state == S_RWAIT) && !mem_rvalid);

    // Write the pushed entry, or fold a merged write into the tail entry
    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_idx] <= port_a;
            fifo_ds[wr_idx]   <= port_ds;
            fifo_data[wr_idx] <= port_d;
        end
`ifdef DL_BYTE_MERGE_EN
        if (merge_ok) begin
            fifo_ds[tail_idx]   <= fifo_ds[tail_idx] | port_ds;
            fifo_data[tail_idx] <= {port_ds[1] ? port_d[15:8] : fifo_data[tail_idx][15:8],
                                    port_ds[0] ? port_d[7:0]  : fifo_data[tail_idx][7:0]};
        end
`endif
    end

    // Advance the FIFO pointers; reset empties the FIFO
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Command FSM with registered memory outputs, port ack/data and busy
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_ds    <= 2'b00;
            mem_wdata <= 16'h0000;
            port_ack  <= 1'b0;
            port_q    <= 16'h0000;
            busy      <= 1'b0;
        end else begin
            busy <= (count_nxt != '0) || rd_inflight_nxt;

            if (wr_accept || rd_done) port_ack <= ~port_ack;

            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        mem_addr  <= fifo_addr[rd_idx];
                        mem_ds    <= fifo_ds[rd_idx];
                        mem_wdata <= fifo_data[rd_idx];
                        mem_we    <= 1'b1;
                        mem_valid <= 1'b1;
                        state     <= S_WR;
                    end else if (rd_issue) begin
                        mem_addr  <= port_a;
                        mem_ds    <= port_ds;
                        mem_wdata <= port_d;
                        mem_we    <= 1'b0;
                        mem_valid <= 1'b1;
                        state     <= S_RD;
                    end
                end
                S_WR: begin
                    if (mem_ready) begin
                        if (count != CNT_ONE) begin
                            mem_addr  <= fifo_addr[rd_nxt_idx];
                            mem_ds    <= fifo_ds[rd_nxt_idx];
                            mem_wdata <= fifo_data[rd_nxt_idx];
                        end else begin
                            mem_valid <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    if (mem_rvalid) begin
                        port_q <= mem_rdata;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dl_port_responder.sv
// tb_dl_port_responder
// Directed stimulus with a command scoreboard: every request pushes its
// expected memory command; a monitor pops and compares on each handshake.
module tb_dl_port_responder;

    localparam int AW = 23;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [1:0]    ds;
        logic [15:0]   wdata;
    } cmd_t;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          port_req;
    logic          port_ack;
    logic [AW-1:0] port_a;
    logic [1:0]    port_ds;
    logic          port_we;
    logic [15:0]   port_d;
    logic [15:0]   port_q;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [1:0]    mem_ds;
    logic [15:0]   mem_wdata;
    logic          mem_rvalid;
    logic [15:0]   mem_rdata;
    logic          busy;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cmd_seen = 0;
    cmd_t exp_q[$];

    dl_port_responder #(.AW(AW), .DEPTH(4)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .port_req   (port_req),
        .port_ack   (port_ack),
        .port_a     (port_a),
        .port_ds    (port_ds),
        .port_we    (port_we),
        .port_d     (port_d),
        .port_q     (port_q),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_ds     (mem_ds),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compare every accepted command against the scoreboard
    initial begin
        cmd_t e;
        forever begin
            @(negedge clk_sys);
            if (reset === 1'b0 && mem_valid === 1'b1 && mem_ready === 1'b1) begin
                cmd_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_cmd: got addr 0x%0h we %0b, expected no command", mem_addr, mem_we);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_addr", 64'(mem_addr), 64'(e.addr));
                    check("cmd_we",   64'(mem_we),   64'(e.we));
                    check("cmd_ds",   64'(mem_ds),   64'(e.ds));
                    if (e.we) check("cmd_wdata", 64'(mem_wdata), 64'(e.wdata));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue_req(input logic we, input logic [AW-1:0] a, input logic [1:0] ds, input logic [15:0] d);
        port_we  = we;
        port_a   = a;
        port_ds  = ds;
        port_d   = d;
        port_req = ~port_req;
    endtask

    task automatic wait_ack(input string name, output int cycles);
        cycles = 0;
        while (port_ack !== port_req && cycles < 100) begin
            @(posedge clk_sys);
            #1;
            cycles++;
        end
        check(name, 64'(port_ack), 64'(port_req));
    endtask

    task automatic post_write(input string name, input logic [AW-1:0] a, input logic [1:0] ds,
                              input logic [15:0] d, output int cycles);
        exp_q.push_back('{addr: a, we: 1'b1, ds: ds, wdata: d});
        issue_req(1'b1, a, ds, d);
        wait_ack(name, cycles);
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while ((busy !== 1'b0 || mem_valid !== 1'b0) && c < 200) begin
            @(posedge clk_sys);
            #1;
            c++;
        end
        check({name, "_idle"}, 64'(busy), 64'(0));
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_rd_handshake(input string name);
        int c = 0;
        do begin
            @(negedge clk_sys);
            c++;
        end while (!(mem_valid === 1'b1 && mem_ready === 1'b1 && mem_we === 1'b0) && c < 100);
        check(name, 64'(mem_valid & ~mem_we), 64'(1));
    endtask

    initial begin
        int cyc;
        int base;
        int n_fast;

        reset      = 1'b1;
        port_req   = 1'b0;
        port_a     = '0;
        port_ds    = 2'b00;
        port_we    = 1'b0;
        port_d     = 16'h0000;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;

        // Reset values
        #12;
        check("rst_port_ack",  64'(port_ack),  64'(0));
        check("rst_port_q",    64'(port_q),    64'(0));
        check("rst_mem_valid", 64'(mem_valid), 64'(0));
        check("rst_mem_addr",  64'(mem_addr),  64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        @(posedge clk_sys); #1;
        reset = 1'b0;
        @(posedge clk_sys); #1;

        // Posted writes fill the FIFO while memory stalls; the fifth is held
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            post_write("posted_ack", AW'(32'h10 + i), 2'b01, 16'(32'h1000 + i), cyc);
            if (i == 0) begin
                check("wr_ack_latency", 64'(cyc), 64'(1));
                check("busy_after_push", 64'(busy), 64'(1));
            end
        end
        exp_q.push_back('{addr: AW'(32'h14), we: 1'b1, ds: 2'b01, wdata: 16'h1004});
        issue_req(1'b1, AW'(32'h14), 2'b01, 16'h1004);
        repeat (5) begin
            @(posedge clk_sys); #1;
        end
        check("full_write_held", 64'(port_ack ^ port_req), 64'(1));
        check("stalled_head_addr", 64'(mem_addr), 64'(32'h10));
        mem_ready = 1'b1;
        wait_ack("held_write_ack", cyc);
        wait_idle("posted");

        // A read queued behind a write must reach memory after it
        post_write("rd_order_wr_ack", AW'(32'h20), 2'b11, 16'hBEEF, cyc);
        exp_q.push_back('{addr: AW'(32'h20), we: 1'b0, ds: 2'b11, wdata: 16'h0000});
        issue_req(1'b0, AW'(32'h20), 2'b11, 16'h0000);
        wait_rd_handshake("rd_cmd_issued");
        @(posedge clk_sys); #1;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBEEF;
        @(negedge clk_sys);
        check("rd_ack_not_early", 64'(port_ack ^ port_req), 64'(1));
        @(posedge clk_sys); #1;
        mem_rvalid = 1'b0;
        check("rd_ack", 64'(port_ack), 64'(port_req));
        check("rd_port_q", 64'(port_q), 64'(16'hBEEF));
        wait_idle("read");

        // Backpressure: command fields hold while ready stays low
        mem_ready = 1'b0;
        post_write("bp_wr_ack", AW'(32'h40), 2'b10, 16'h5A00, cyc);
        cyc = 0;
        while (mem_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk_sys); #1;
            cyc++;
        end
        check("bp_valid", 64'(mem_valid), 64'(1));
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_sys);
            check("bp_hold", {23'b0, mem_addr, mem_ds, mem_wdata},
                  {23'b0, AW'(32'h40), 2'b10, 16'h5A00});
        end
        @(posedge clk_sys); #1;
        mem_ready = 1'b1;
        wait_idle("backpressure");

        // Pointer wrap: 20 back-to-back writes at full rate
        base   = cmd_seen;
        n_fast = 0;
        for (int i = 0; i < 20; i++) begin
            post_write("wrap_ack", AW'(32'h100 + i), 2'b11, 16'(i * 32'h0111), cyc);
            if (cyc == 1) n_fast++;
        end
        check("wrap_one_per_clock", 64'(n_fast), 64'(20));
        wait_idle("wrap");
        check("wrap_cmd_count", 64'(cmd_seen - base), 64'(20));

        // Byte merge behind a stalled head
        mem_ready = 1'b0;
        base = cmd_seen;
        post_write("merge_head_ack", AW'(32'h50), 2'b11, 16'h1234, cyc);
`ifdef DL_BYTE_MERGE_EN
        exp_q.push_back('{addr: AW'(32'h30), we: 1'b1, ds: 2'b11, wdata: 16'hBBAA});
`else
        exp_q.push_back('{addr: AW'(32'h30), we: 1'b1, ds: 2'b01, wdata: 16'h00AA});
        exp_q.push_back('{addr: AW'(32'h30), we: 1'b1, ds: 2'b10, wdata: 16'hBB00});
`endif
        issue_req(1'b1, AW'(32'h30), 2'b01, 16'h00AA);
        wait_ack("merge_lo_ack", cyc);
        issue_req(1'b1, AW'(32'h30), 2'b10, 16'hBB00);
        wait_ack("merge_hi_ack", cyc);
        @(posedge clk_sys); #1;
        mem_ready = 1'b1;
        wait_idle("merge");
`ifdef DL_BYTE_MERGE_EN
        check("merge_cmd_count", 64'(cmd_seen - base), 64'(2));
`else
        check("merge_cmd_count", 64'(cmd_seen - base), 64'(3));
`endif

        // Asynchronous reset while a read waits for data
        exp_q.push_back('{addr: AW'(32'h60), we: 1'b0, ds: 2'b11, wdata: 16'h0000});
        issue_req(1'b0, AW'(32'h60), 2'b11, 16'h0000);
        wait_rd_handshake("rst_rd_issued");
        @(posedge clk_sys); #3;
        reset    = 1'b1;
        port_req = 1'b0;
        #1;
        check("midrst_port_ack",  64'(port_ack),  64'(0));
        check("midrst_mem_valid", 64'(mem_valid), 64'(0));
        check("midrst_busy",      64'(busy),      64'(0));
        check("midrst_port_q",    64'(port_q),    64'(0));
        @(negedge clk_sys);
        reset = 1'b0;
        @(posedge clk_sys); #1;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h1234;
        @(posedge clk_sys); #1;
        mem_rvalid = 1'b0;
        check("late_rvalid_q",   64'(port_q),   64'(0));
        check("late_rvalid_ack", 64'(port_ack), 64'(0));
        @(posedge clk_sys); #1;
        check("late_rvalid_busy",  64'(busy),      64'(0));
        check("late_rvalid_valid", 64'(mem_valid), 64'(0));
        check("final_sb_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
